// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states and
// datapath mux/ALU select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ST_RST    = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD  = 4'd4;
  localparam logic [3:0] ST_MEMWB  = 4'd5;
  localparam logic [3:0] ST_MEMWR  = 4'd6;
  localparam logic [3:0] ST_EXEC   = 4'd7;
  localparam logic [3:0] ST_RWB    = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_JUMP   = 4'd10;
  localparam logic [3:0] ST_ADDIEX = 4'd11;
  localparam logic [3:0] ST_ADDIWB = 4'd12;
  localparam logic [3:0] ST_TRAP   = 4'd13;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake and are covered by the timeout.
  function automatic logic is_mem_wait(input logic [3:0] st);
    return (st == ST_FETCH) || (st == ST_MEMRD) || (st == ST_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle FSM (master) and the shared datapath (slave).
interface multicycle_ctrl_fsm_if;

  logic [31:0] Instruction;
  logic        Zero;
  logic        MemReady;
  logic        PCEn;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        Trap;
  logic [3:0]  State;

  modport master (
    input  Instruction, Zero, MemReady,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, Trap, State
  );

  modport slave (
    output Instruction, Zero, MemReady,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, Trap, State
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on MemReady and flags a timeout on the last allowed cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic Clk,
  input  logic Rst,
  input  logic waiting,
  input  logic clear,
  input  logic mem_ready,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || mem_ready) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready on the final cycle still completes the access.
  assign timeout = (MEM_TIMEOUT != 0) && waiting && !mem_ready &&
                   (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Control FSM for the shared multi-cycle MIPS datapath; outputs decode from the state
// register, with only IRWrite/PCEn in FETCH and PCEn in BRANCH qualified by inputs.
module multicycle_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input logic                    Clk,
  input logic                    Rst,
  multicycle_ctrl_fsm_if.master  bus
);

  logic [3:0] state_q, state_d;
  logic [5:0] opcode;
  logic       timeout;
  logic       pc_write;
  logic       pc_write_cond;
  logic       unused_ir;

  assign opcode    = bus.Instruction[31:26];
  assign unused_ir = ^bus.Instruction[25:0];

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .Clk       (Clk),
    .Rst       (Rst),
    .waiting   (is_mem_wait(state_q)),
    .clear     (is_mem_wait(state_d) && (state_d != state_q)),
    .mem_ready (bus.MemReady),
    .timeout   (timeout)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH:  state_d = bus.MemReady ? ST_DECODE : (timeout ? ST_TRAP : ST_FETCH);
      ST_DECODE: begin
        unique case (opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD :
                           (opcode == OP_SW) ? ST_MEMWR : ST_TRAP;
      ST_MEMRD:  state_d = bus.MemReady ? ST_MEMWB : (timeout ? ST_TRAP : ST_MEMRD);
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  state_d = bus.MemReady ? ST_FETCH : (timeout ? ST_TRAP : ST_MEMWR);
      ST_EXEC:   state_d = ST_RWB;
      ST_RWB:    state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      default:   state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = SRCB_RT;
    bus.ALUOp     = ALUOP_ADD;
    bus.PCSource  = PCSRC_ALU;
    bus.Trap      = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = bus.MemReady;
        pc_write    = bus.MemReady;
      end
      ST_DECODE: bus.ALUSrcB = SRCB_IMM_SH;
      ST_MEMADR, ST_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
      end
      ST_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      ST_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      ST_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      ST_RWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      ST_BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUOp     = ALUOP_SUB;
        bus.PCSource  = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      ST_JUMP: begin
        bus.PCSource = PCSRC_JUMP;
        pc_write     = 1'b1;
      end
      ST_ADDIWB: bus.RegWrite = 1'b1;
      ST_TRAP:   bus.Trap     = 1'b1;
      default: ;
    endcase
  end

  assign bus.PCEn  = pc_write | (pc_write_cond & bus.Zero);
  assign bus.State = state_q;

endmodule
